// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Holds the controller state encodings and the requester (owner) ids used by
// mem_port_arbiter and its round-robin picker arb_rr2.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

    // Largest memory latency the 2-bit access counter can sequence.
    localparam int MAX_MEM_LAT = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational round-robin picker.
// Ports:
//   req[1:0]   : request vector, bit 0 = cpu, bit 1 = io
//   last_owner : id of the requester served most recently
//   gnt_valid  : at least one request is pending
//   gnt_id     : id of the chosen requester (valid when gnt_valid)
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = OWN_CPU;
        if (req == 2'b11) begin
            // Conflict: the side that did not go last wins.
            gnt_id = ~last_owner;
        end else if (req[1]) begin
            gnt_id = OWN_IO;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency unified memory between the processor
// control unit (cpu_*) and the I/O / program-loader port (io_*).
// Each granted access runs IDLE -> BUSY (MEM_LAT cycles) -> DONE (ack pulse).
// Ports:
//   CLK, Reset                 : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      : processor request, held until cpu_ack
//   cpu_rdata, cpu_ack         : registered read data, one-cycle completion
//   cpu_stall                  : processor request pending and not yet acked
//   io_req/we/addr/wdata       : I/O port request, same handshake as cpu
//   io_rdata, io_ack           : I/O read data and completion pulse
//   mem_en/we/addr/wdata       : memory macro strobes
//   mem_rdata                  : memory read data, sampled MEM_LAT cycles in
//   busy                       : access in flight (BUSY or DONE)
//   owner                      : owner of current/most recent access (0 cpu, 1 io)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : gen_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be in 1..4");
        end
    endgenerate

    localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_owner_reg, last_owner_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [1:0]        ack;
    logic              gnt_valid;
    logic              gnt_id;
    logic              capture;

    arb_rr2 u_rr (
        .req        ({io_req, cpu_req}),
        .last_owner (last_owner_reg),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_IO;
            last_owner_reg <= OWN_IO;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            cnt_reg        <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        cnt_next        = cnt_reg;
        case (state_reg)
            IDLE: begin
                // Live requests are re-sampled here, so a request dropped
                // before its grant is simply never served.
                if (gnt_valid) begin
                    owner_next = gnt_id;
                    if (gnt_id == OWN_IO) begin
                        addr_next  = io_addr;
                        we_next    = io_we;
                        wdata_next = io_wdata;
                    end else begin
                        addr_next  = cpu_addr;
                        we_next    = cpu_we;
                        wdata_next = cpu_wdata;
                    end
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                last_owner_next = owner_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data is taken on the edge leaving BUSY; writes leave rdata alone.
    assign capture = (state_reg == BUSY) && (cnt_reg == CNT_LAST) && !we_reg;

    // One read-data register and one ack per requester, selected by owner.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            always_ff @(posedge CLK) begin
                if (Reset) begin
                    rdata_reg[gi] <= '0;
                end else if (capture && (owner_reg == 1'(gi))) begin
                    rdata_reg[gi] <= mem_rdata;
                end
            end
            assign ack[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign cpu_rdata = rdata_reg[OWN_CPU];
    assign io_rdata  = rdata_reg[OWN_IO];
    assign cpu_ack   = ack[OWN_CPU];
    assign io_ack    = ack[OWN_IO];
    assign cpu_stall = cpu_req & ~cpu_ack;

    assign mem_en    = (state_reg == BUSY);
    // Strobe the write only on the first BUSY cycle so it lands exactly once.
    assign mem_we    = (state_reg == BUSY) && (cnt_reg == 2'd0) && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = (state_reg != IDLE);
    assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each attached to a small behavioural memory.
module tb_mem_port_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic Reset;

    logic        cpu_req1, cpu_we1, cpu_ack1, cpu_stall1;
    logic [15:0] cpu_addr1, cpu_wdata1, cpu_rdata1;
    logic        io_req1, io_we1, io_ack1;
    logic [15:0] io_addr1, io_wdata1, io_rdata1;
    logic        mem_en1, mem_we1, busy1, owner1;
    logic [15:0] mem_addr1, mem_wdata1, mem_rdata1;

    logic        cpu_req3, cpu_we3, cpu_ack3, cpu_stall3;
    logic [15:0] cpu_addr3, cpu_wdata3, cpu_rdata3;
    logic        io_req3, io_we3, io_ack3;
    logic [15:0] io_addr3, io_wdata3, io_rdata3;
    logic        mem_en3, mem_we3, busy3, owner3;
    logic [15:0] mem_addr3, mem_wdata3, mem_rdata3;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
        .io_req(io_req1), .io_we(io_we1), .io_addr(io_addr1), .io_wdata(io_wdata1),
        .io_rdata(io_rdata1), .io_ack(io_ack1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut3 (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
        .io_req(io_req3), .io_we(io_we3), .io_addr(io_addr3), .io_wdata(io_wdata3),
        .io_rdata(io_rdata3), .io_ack(io_ack3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
    );

    // Behavioural memories. Latency-1 memory: data visible during the enable
    // cycle. Latency-3 memory: two pipeline stages behind the array read, so
    // data only becomes correct on the third enable cycle.
    logic [15:0] mem1 [512];
    logic [15:0] mem3 [512];
    logic [15:0] rd0_3, pipe1_3, pipe2_3;

    always_comb mem_rdata1 = (mem_en1 && !mem_we1) ? mem1[mem_addr1[8:0]] : 16'hDEAD;
    always_comb rd0_3      = (mem_en3 && !mem_we3) ? mem3[mem_addr3[8:0]] : 16'hDEAD;
    assign mem_rdata3 = pipe2_3;

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem1[i] = 16'h0000;
            mem3[i] = 16'h0000;
        end
        mem1[9'h040] = 16'hBEEF;
        mem1[9'h1FF] = 16'hFFFF;
        mem3[9'h100] = 16'h00A5;
        mem3[9'h002] = 16'h7777;
        pipe1_3 = 16'h0000;
        pipe2_3 = 16'h0000;
        forever begin
            @(posedge CLK);
            if (mem_en1 && mem_we1) mem1[mem_addr1[8:0]] <= mem_wdata1;
            if (mem_en3 && mem_we3) mem3[mem_addr3[8:0]] <= mem_wdata3;
            pipe1_3 <= rd0_3;
            pipe2_3 <= pipe1_3;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          dut;    // 1 or 3, equal to that instance's MEM_LAT
        bit          port;   // 0 = cpu, 1 = io
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;    // requester rdata expected at its ack
    } vec_t;

    vec_t tbl [10];

    task automatic drive(input int dut, input bit port, input bit req, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (dut == 1) begin
            if (!port) begin cpu_req1 = req; cpu_we1 = we; cpu_addr1 = addr; cpu_wdata1 = wdata; end
            else       begin io_req1  = req; io_we1  = we; io_addr1  = addr; io_wdata1  = wdata; end
        end else begin
            if (!port) begin cpu_req3 = req; cpu_we3 = we; cpu_addr3 = addr; cpu_wdata3 = wdata; end
            else       begin io_req3  = req; io_we3  = we; io_addr3  = addr; io_wdata3  = wdata; end
        end
    endtask

    // {own ack, other ack, mem_en, mem_we}
    function automatic logic [3:0] sample(input int dut, input bit port);
        if (dut == 1) return port ? {io_ack1, cpu_ack1, mem_en1, mem_we1}
                                  : {cpu_ack1, io_ack1, mem_en1, mem_we1};
        return port ? {io_ack3, cpu_ack3, mem_en3, mem_we3}
                    : {cpu_ack3, io_ack3, mem_en3, mem_we3};
    endfunction

    function automatic logic [15:0] rdata_of(input int dut, input bit port);
        if (dut == 1) return port ? io_rdata1 : cpu_rdata1;
        return port ? io_rdata3 : cpu_rdata3;
    endfunction

    function automatic logic stall_of(input int dut);
        return (dut == 1) ? cpu_stall1 : cpu_stall3;
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    // One complete request/ack handshake; entered and left at posedge+1.
    task automatic xfer(input vec_t v);
        int cyc, en_n, we_n, st_n, oth_n;
        bit got;
        logic [15:0] rd;
        logic [3:0] s;
        cyc = 0; en_n = 0; we_n = 0; st_n = 0; oth_n = 0; got = 1'b0; rd = 16'h0000;
        drive(v.dut, v.port, 1'b1, v.we, v.addr, v.wdata);
        while (!got && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            s = sample(v.dut, v.port);
            if (s[1]) en_n++;
            if (s[0]) we_n++;
            if (s[2]) oth_n++;
            if (!v.port && stall_of(v.dut)) st_n++;
            if (s[3]) begin
                got = 1'b1;
                rd  = rdata_of(v.dut, v.port);
            end
        end
        @(posedge CLK);
        #1;
        drive(v.dut, v.port, 1'b0, 1'b0, 16'h0000, 16'h0000);
        $display("xfer lat=%0d port=%s we=%0d addr=%h wdata=%h rdata=%h cycles=%0d",
                 v.dut, v.port ? "io" : "cpu", v.we, v.addr, v.wdata, rd, cyc);
        chk("ack_latency", cyc, v.dut + 2);
        chk("mem_en_cycles", en_n, v.dut);
        chk("mem_we_cycles", we_n, v.we ? 1 : 0);
        if (!v.port) chk("cpu_stall_cycles", st_n, v.dut + 1);
        chk("other_ack_seen", oth_n, 0);
        chk("rdata", 32'(rd), 32'(v.exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack, both, ca, ia, bz;
        int ack_cyc [4];
        bit ack_id [4];
        bit drop;

        tbl[0] = '{1, 1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000};
        tbl[1] = '{1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        tbl[2] = '{1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
        tbl[3] = '{1, 1'b1, 1'b0, 16'h01FF, 16'h0000, 16'hFFFF};
        tbl[4] = '{1, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 16'hBEEF};
        tbl[5] = '{1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A};
        tbl[6] = '{3, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h7777};
        tbl[7] = '{3, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h00A5};
        tbl[8] = '{3, 1'b1, 1'b1, 16'h0101, 16'hC3C3, 16'h00A5};
        tbl[9] = '{3, 1'b1, 1'b0, 16'h0101, 16'h0000, 16'hC3C3};

        Reset = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(3, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        do_reset();

        // Reset state
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_owner", 32'(owner1), 32'd1);
        chk("rst_mem_en", 32'(mem_en1), 32'd0);
        chk("rst_mem_we", 32'(mem_we1), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack1), 32'd0);
        chk("rst_io_ack", 32'(io_ack1), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata1), 32'd0);
        chk("rst_io_rdata", 32'(io_rdata1), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr1), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata1), 32'd0);
        chk("rst_mem_addr_l3", 32'(mem_addr3), 32'd0);
        chk("rst_owner_l3", 32'(owner3), 32'd1);
        chk("rst_busy_l3", 32'(busy3), 32'd0);

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) xfer(tbl[i]);
        chk("nonowner_cpu_rdata_l3", 32'(cpu_rdata3), 32'h7777);
        chk("nonowner_io_rdata_l1", 32'(io_rdata1), 32'hFFFF);

        // Simultaneous continuous requests from reset: cpu first, then alternate
        do_reset();
        drive(1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        n_ack = 0; both = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (cpu_ack1 && io_ack1) both++;
            if (cpu_ack1 || io_ack1) begin
                if (n_ack < 4) begin
                    ack_cyc[n_ack] = c;
                    ack_id[n_ack]  = io_ack1;
                end
                $display("conflict ack cycle=%0d owner=%s", c, io_ack1 ? "io" : "cpu");
                n_ack++;
            end
        end
        @(posedge CLK);
        #1;
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("conflict_ack_count", n_ack, 4);
        chk("conflict_both_acks", both, 0);
        for (int i = 0; i < 4 && i < n_ack; i++) begin
            chk("conflict_ack_cycle", ack_cyc[i], 2 + 3 * i);
            chk("conflict_ack_owner", 32'(ack_id[i]), 32'(i % 2));
        end
        chk("conflict_cpu_rdata", 32'(cpu_rdata1), 32'h1234);
        chk("conflict_io_rdata", 32'(io_rdata1), 32'hBEEF);

        // io request pulsed for one cycle while a cpu access is in BUSY
        ca = 0; ia = 0; bz = 0;
        drive(1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            if (cpu_ack1) ca++;
            if (io_ack1) ia++;
            if (c >= 3 && busy1) bz++;
            drop = cpu_ack1;
            @(posedge CLK);
            #1;
            if (c == 0) drive(1, 1'b1, 1'b1, 1'b0, 16'h01FF, 16'h0000);
            if (c == 1) drive(1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            if (drop) drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        $display("dropped io req: cpu_acks=%0d io_acks=%0d busy_after=%0d", ca, ia, bz);
        chk("dropped_cpu_acks", ca, 1);
        chk("dropped_io_acks", ia, 0);
        chk("dropped_busy_after", bz, 0);
        chk("dropped_cpu_rdata", 32'(cpu_rdata1), 32'hBEEF);

        // Reset while an io read is in BUSY
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("pre_reset_mem_en", 32'(mem_en1), 32'd1);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("busy_rst_mem_en", 32'(mem_en1), 32'd0);
        chk("busy_rst_mem_we", 32'(mem_we1), 32'd0);
        chk("busy_rst_busy", 32'(busy1), 32'd0);
        chk("busy_rst_owner", 32'(owner1), 32'd1);
        chk("busy_rst_io_rdata", 32'(io_rdata1), 32'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        ia = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (io_ack1) ia++;
        end
        @(posedge CLK);
        #1;
        $display("reset in BUSY: io_acks_after=%0d", ia);
        chk("busy_rst_no_io_ack", ia, 0);
        xfer('{1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
